display7_pager: RTL and testbench

- Parametrised, registered 7-segment display controller for the board HEX digits.
- Shows any DATA_W-bit debug word (for example a 64-bit datapath register) across DIGITS hex displays.
- Splits the word into fixed pages. Pages are selected manually, stepped by pulse, or rotated automatically by an internal timer.
- Adds value snapshot, freeze and leading-zero blanking. Sits between the processor's debug outputs and the board HEX pins.

---
 rtl/display7_pager.sv | 154 +++++++++++++++
 tb/tb_display7_pager.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display7_pager.sv
// display7_pager
//   Registered 7-segment controller that pages a DATA_W-bit debug word across
//   DIGITS hex displays. The word is captured into a snapshot register and all
//   digits are rendered from that snapshot. The page is chosen manually,
//   stepped by a rising edge on iNext, rotated by an internal prescaler, or
//   frozen.
//
// Ports
//   iCLK      system clock, rising edge
//   iRST_n    asynchronous active-low reset
//   iData     word to display
//   iLoad     capture iData into the snapshot on this edge
//   iMode     00 manual, 01 step, 10 auto, 11 freeze
//   iPage     page requested in manual mode (clamped to the last page)
//   iNext     step request in step mode (rising edge acts)
//   iBlankLZ  1 = blank digits above the most significant nonzero nibble
//   oHEX      segments, digit d at [7d+6:7d], bit0=a..bit6=g, active-low
//   oPage     page currently shown
module display7_pager #(
    parameter int DATA_W   = 64,
    parameter int DIGITS   = 6,
    parameter int TICK_DIV = 50000000,
    localparam int NIB     = DATA_W / 4,
    localparam int NPAGES  = (NIB + DIGITS - 1) / DIGITS,
    localparam int PAGE_W  = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic [DATA_W-1:0]     iData,
    input  logic                  iLoad,
    input  logic [1:0]            iMode,
    input  logic [PAGE_W-1:0]     iPage,
    input  logic                  iNext,
    input  logic                  iBlankLZ,
    output logic [7*DIGITS-1:0]   oHEX,
    output logic [PAGE_W-1:0]     oPage
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NPAGES - 1);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_STEP   = 2'b01;
    localparam logic [1:0] MODE_AUTO   = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    logic [DATA_W-1:0]  snapshot;
    logic [PAGE_W-1:0]  page;
    logic [CNT_W-1:0]   prescaler;
    logic               nextQ;
    logic [1:0]         modeQ;
    logic               blankQ;

    logic               nextRise;
    logic               modeChanged;
    logic               autoTick;
    logic [PAGE_W-1:0]  pageInc;
    logic [PAGE_W-1:0]  pageClamped;
    logic [7*DIGITS-1:0] hexNext;
    int                 msn;
    int                 nibIdx;
    logic [3:0]         nibVal;

    function automatic logic [6:0] hexSeg(input logic [3:0] v);
        case (v)
            4'h0: hexSeg = 7'h40;
            4'h1: hexSeg = 7'h79;
            4'h2: hexSeg = 7'h24;
            4'h3: hexSeg = 7'h30;
            4'h4: hexSeg = 7'h19;
            4'h5: hexSeg = 7'h12;
            4'h6: hexSeg = 7'h02;
            4'h7: hexSeg = 7'h78;
            4'h8: hexSeg = 7'h00;
            4'h9: hexSeg = 7'h10;
            4'hA: hexSeg = 7'h08;
            4'hB: hexSeg = 7'h03;
            4'hC: hexSeg = 7'h46;
            4'hD: hexSeg = 7'h21;
            4'hE: hexSeg = 7'h06;
            default: hexSeg = 7'h0E;
        endcase
    endfunction

    assign nextRise    = iNext & ~nextQ;
    assign modeChanged = (iMode != modeQ);
    // Prescaler is held at 0 outside auto, so on auto entry it starts from 0
    // and the first advance lands exactly TICK_DIV edges later.
    assign autoTick    = (iMode == MODE_AUTO) && (prescaler == TICK_LAST);
    // With a single page LAST_PAGE is 0, so both of these collapse to 0.
    assign pageInc     = (page == LAST_PAGE) ? '0 : page + 1'b1;
    assign pageClamped = (iPage > LAST_PAGE) ? LAST_PAGE : iPage;

    // Render the digits of the current page from registered state only.
    always_comb begin
        msn     = 0;
        nibIdx  = 0;
        nibVal  = 4'h0;
        hexNext = '1;
        for (int k = 0; k < NIB; k++) begin
            if (snapshot[4*k +: 4] != 4'h0) msn = k;
        end
        for (int d = 0; d < DIGITS; d++) begin
            nibIdx = int'(page) * DIGITS + d;
            nibVal = 4'h0;
            for (int k = 0; k < NIB; k++) begin
                if (k == nibIdx) nibVal = snapshot[4*k +: 4];
            end
            if (nibIdx >= NIB || (blankQ && nibIdx > msn))
                hexNext[7*d +: 7] = 7'h7F;
            else
                hexNext[7*d +: 7] = hexSeg(nibVal);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            snapshot  <= '0;
            page      <= '0;
            prescaler <= '0;
            nextQ     <= 1'b0;
            modeQ     <= MODE_MANUAL;
            blankQ    <= 1'b0;
            oHEX      <= '1;
            oPage     <= '0;
        end else begin
            nextQ  <= iNext;
            modeQ  <= iMode;
            blankQ <= iBlankLZ;

            if (iLoad) snapshot <= iData;

            if (iMode != MODE_AUTO || modeChanged || prescaler == TICK_LAST)
                prescaler <= '0;
            else
                prescaler <= prescaler + 1'b1;

            case (iMode)
                MODE_MANUAL: page <= pageClamped;
                MODE_STEP:   if (nextRise) page <= pageInc;
                MODE_AUTO:   if (autoTick) page <= pageInc;
                default:     page <= page;
            endcase

            // Freeze holds the visible outputs even while the snapshot loads.
            if (iMode != MODE_FREEZE) begin
                oHEX  <= hexNext;
                oPage <= page;
            end
        end
    end

endmodule

// File: tb/tb_display7_pager.sv
module tb_display7_pager;

    localparam int DATA_W   = 64;
    localparam int DIGITS   = 6;
    localparam int TICK_DIV = 4;
    localparam int NIB      = 16;
    localparam int NPAGES   = 3;

    logic        clk;
    logic        rstN;
    logic [63:0] data;
    logic        load;
    logic [1:0]  mode;
    logic [1:0]  pageIn;
    logic        next;
    logic        blankLZ;
    logic [41:0] hex;
    logic [1:0]  pageOut;

    int passCount;
    int checkCount;

    // Reference model state
    logic [63:0] mSnap;
    int          mPage;
    logic        mBlank;
    logic        mPrevNext;
    logic [1:0]  mPrevMode;
    int          mAutoCount;
    logic [41:0] expHex;
    logic [1:0]  expPage;

    logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    display7_pager #(
        .DATA_W(DATA_W),
        .DIGITS(DIGITS),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .iCLK(clk),
        .iRST_n(rstN),
        .iData(data),
        .iLoad(load),
        .iMode(mode),
        .iPage(pageIn),
        .iNext(next),
        .iBlankLZ(blankLZ),
        .oHEX(hex),
        .oPage(pageOut)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", passCount, checkCount);
        $fatal(1, "watchdog");
    end

    // Model: what the display should show for a snapshot, page and blanking flag.
    function automatic logic [41:0] render(input logic [63:0] s, input int p, input logic b);
        logic [41:0] r;
        int top;
        int n;
        logic found;
        logic [3:0] nib;
        top = 0;
        found = 1'b0;
        for (int i = NIB - 1; i >= 0; i--) begin
            if (!found && ((s >> (4 * i)) & 64'hF) != 64'h0) begin
                top = i;
                found = 1'b1;
            end
        end
        r = '1;
        for (int d = 0; d < DIGITS; d++) begin
            n = p * DIGITS + d;
            if (n < NIB && !(b && n > top)) begin
                nib = 4'((s >> (4 * n)) & 64'hF);
                r[7*d +: 7] = segTab[nib];
            end
        end
        return r;
    endfunction

    task automatic modelReset();
        mSnap      = '0;
        mPage      = 0;
        mBlank     = 1'b0;
        mPrevNext  = 1'b0;
        mPrevMode  = 2'b00;
        mAutoCount = 0;
        expHex     = '1;
        expPage    = 2'd0;
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic modelEdge();
        if (!rstN) begin
            modelReset();
        end else begin
            if (mode != 2'b11) begin
                expHex  = render(mSnap, mPage, mBlank);
                expPage = 2'(mPage);
            end
            mBlank = blankLZ;
            if (load) mSnap = data;
            case (mode)
                2'b00: mPage = (int'(pageIn) > NPAGES - 1) ? NPAGES - 1 : int'(pageIn);
                2'b01: if (next && !mPrevNext) mPage = (mPage + 1) % NPAGES;
                2'b10: begin
                    if (mPrevMode == 2'b10) mAutoCount = mAutoCount + 1;
                    else mAutoCount = 0;
                    if (mAutoCount > 0 && (mAutoCount % TICK_DIV) == 0)
                        mPage = (mPage + 1) % NPAGES;
                end
                default: ;
            endcase
            mPrevNext = next;
            mPrevMode = mode;
        end
    endtask

    // Driver: one clock edge, model follows, outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        modelReset();
        repeat (3) tick();
        checkCount++;
        if (hex !== {42{1'b1}}) $display("FAIL reset_hex: got %h want %h", hex, {42{1'b1}});
        else passCount++;
        checkCount++;
        if (pageOut !== 2'd0) $display("FAIL reset_page: got %0d want 0", pageOut);
        else passCount++;
        rstN = 1'b1;
        tick();
        checkCount++;
        if (hex !== expHex) $display("FAIL reset_release_hex: got %h want %h", hex, expHex);
        else passCount++;
    endtask

    task automatic test_manual();
        data = 64'h0123_4567_89AB_CDEF;
        load = 1'b1;
        mode = 2'b00;
        pageIn = 2'd0;
        tick();
        load = 1'b0;
        tick();
        checkCount++;
        if (hex !== {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E})
            $display("FAIL manual_page0_hex: got %h want %h", hex, {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
        else passCount++;
        checkCount++;
        if (hex !== expHex) $display("FAIL manual_page0_model: got %h want %h", hex, expHex);
        else passCount++;
        checkCount++;
        if (pageOut !== 2'd0) $display("FAIL manual_page0_page: got %0d want 0", pageOut);
        else passCount++;
        pageIn = 2'd2;
        repeat (2) tick();
        checkCount++;
        if (hex !== {7'h7F, 7'h7F, 7'h40, 7'h79, 7'h24, 7'h30})
            $display("FAIL manual_page2_hex: got %h want %h", hex, {7'h7F, 7'h7F, 7'h40, 7'h79, 7'h24, 7'h30});
        else passCount++;
        pageIn = 2'd3;
        repeat (2) tick();
        checkCount++;
        if (pageOut !== 2'd2) $display("FAIL manual_clamp_page: got %0d want 2", pageOut);
        else passCount++;
        checkCount++;
        if (hex !== expHex) $display("FAIL manual_clamp_hex: got %h want %h", hex, expHex);
        else passCount++;
    endtask

    task automatic test_step();
        logic [1:0] wantSeq [3];
        wantSeq[0] = 2'd2;
        wantSeq[1] = 2'd0;
        wantSeq[2] = 2'd1;
        pageIn = 2'd0;
        next = 1'b0;
        repeat (2) tick();
        mode = 2'b01;
        next = 1'b1;
        repeat (10) tick();
        checkCount++;
        if (pageOut !== 2'd1) $display("FAIL step_held: got %0d want 1", pageOut);
        else passCount++;
        next = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            next = 1'b1;
            tick();
            next = 1'b0;
            tick();
            checkCount++;
            if (pageOut !== wantSeq[i]) $display("FAIL step_pulse%0d: got %0d want %0d", i, pageOut, wantSeq[i]);
            else passCount++;
            checkCount++;
            if (hex !== expHex) $display("FAIL step_pulse%0d_hex: got %h want %h", i, hex, expHex);
            else passCount++;
        end
    endtask

    task automatic test_auto_freeze();
        mode = 2'b00;
        pageIn = 2'd0;
        repeat (2) tick();
        mode = 2'b10;
        for (int c = 0; c < 6; c++) begin
            tick();
            checkCount++;
            if (pageOut !== expPage) $display("FAIL auto_cycle%0d_page: got %0d want %0d", c, pageOut, expPage);
            else passCount++;
        end
        checkCount++;
        if (pageOut !== 2'd1) $display("FAIL auto_first_advance: got %0d want 1", pageOut);
        else passCount++;
        mode = 2'b11;
        tick();
        data = 64'h5;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (6) tick();
        checkCount++;
        if (hex !== {7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10})
            $display("FAIL freeze_hold_hex: got %h want %h", hex, {7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10});
        else passCount++;
        checkCount++;
        if (pageOut !== 2'd1) $display("FAIL freeze_hold_page: got %0d want 1", pageOut);
        else passCount++;
        mode = 2'b00;
        pageIn = 2'd1;
        tick();
        checkCount++;
        if (hex !== {6{7'h40}}) $display("FAIL freeze_exit_hex: got %h want %h", hex, {6{7'h40}});
        else passCount++;
        checkCount++;
        if (hex !== expHex) $display("FAIL freeze_exit_model: got %h want %h", hex, expHex);
        else passCount++;
    endtask

    task automatic test_blanking();
        mode = 2'b00;
        pageIn = 2'd0;
        blankLZ = 1'b1;
        data = 64'h0000_0000_0000_00A0;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checkCount++;
        if (hex !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40})
            $display("FAIL blank_a0: got %h want %h", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40});
        else passCount++;
        data = 64'h0;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checkCount++;
        if (hex !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40})
            $display("FAIL blank_zero: got %h want %h", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        else passCount++;
        blankLZ = 1'b0;
        tick();
        tick();
        checkCount++;
        if (hex !== {6{7'h40}}) $display("FAIL blank_off: got %h want %h", hex, {6{7'h40}});
        else passCount++;
    endtask

    task automatic test_back_to_back();
        mode = 2'b00;
        pageIn = 2'd0;
        next = 1'b0;
        repeat (2) tick();
        // Mode change and iNext rising edge arrive together.
        mode = 2'b01;
        next = 1'b1;
        tick();
        tick();
        checkCount++;
        if (pageOut !== 2'd1) $display("FAIL mode_and_step_same_edge: got %0d want 1", pageOut);
        else passCount++;
        next = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            pageIn  = 2'($urandom_range(0, 3));
            next    = ($urandom_range(0, 2) == 0);
            load    = ($urandom_range(0, 3) == 0);
            data    = {$urandom, $urandom} >> $urandom_range(0, 63);
            blankLZ = ($urandom_range(0, 3) != 0);
            tick();
            checkCount++;
            if (hex !== expHex) begin
                if (errs < 10) $display("FAIL random_hex cycle %0d: got %h want %h", i, hex, expHex);
                errs++;
            end else passCount++;
            checkCount++;
            if (pageOut !== expPage) begin
                if (errs < 10) $display("FAIL random_page cycle %0d: got %0d want %0d", i, pageOut, expPage);
                errs++;
            end else passCount++;
        end
        load = 1'b0;
        next = 1'b0;
    endtask

    task automatic test_async_reset();
        mode = 2'b00;
        pageIn = 2'd0;
        data = 64'h0123_4567_89AB_CDEF;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        mode = 2'b10;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (expPage == 2'd2) break;
        end
        checkCount++;
        if (pageOut !== 2'd2) $display("FAIL async_reached_page2: got %0d want 2", pageOut);
        else passCount++;
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        checkCount++;
        if (hex !== {42{1'b1}}) $display("FAIL async_reset_hex: got %h want %h", hex, {42{1'b1}});
        else passCount++;
        checkCount++;
        if (pageOut !== 2'd0) $display("FAIL async_reset_page: got %0d want 0", pageOut);
        else passCount++;
        @(negedge clk);
        tick();
        rstN = 1'b1;
        mode = 2'b00;
        repeat (2) tick();
        checkCount++;
        if (hex !== expHex) $display("FAIL async_after_release: got %h want %h", hex, expHex);
        else passCount++;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rstN    = 1'b0;
        data    = '0;
        load    = 1'b0;
        mode    = 2'b00;
        pageIn  = 2'd0;
        next    = 1'b0;
        blankLZ = 1'b0;
        modelReset();
        @(negedge clk);

        test_reset();
        test_manual();
        test_step();
        test_auto_freeze();
        test_blanking();
        test_back_to_back();
        test_random();
        test_async_reset();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
